// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port: accept in IDLE, issue in REQ, await response in WAIT.
// Optional macro MEM_ARB_RR_EN selects round-robin on conflicts instead of fixed LSU priority.
module mem_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [DATA_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [DATA_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t              state_q;
  logic                owner_q;
  logic [DATA_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                gnt_ifu;
  logic                gnt_lsu;
`ifdef MEM_ARB_RR_EN
  logic                last_q;
`endif

  // Grants are gated by rst_n so ready drops the instant reset asserts.
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (rst_n && state_q == IDLE) begin
`ifdef MEM_ARB_RR_EN
      if (ifu_req_valid && lsu_req_valid) begin
        gnt_lsu = (last_q == OWN_IFU);
        gnt_ifu = (last_q == OWN_LSU);
      end else begin
        gnt_lsu = lsu_req_valid;
        gnt_ifu = ifu_req_valid;
      end
`else
      gnt_lsu = lsu_req_valid;
      gnt_ifu = ifu_req_valid && !lsu_req_valid;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= OWN_LSU;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_lsu) begin
            state_q <= REQ;
            owner_q <= OWN_LSU;
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wmask;
`ifdef MEM_ARB_RR_EN
            last_q  <= OWN_LSU;
`endif
          end else if (gnt_ifu) begin
            state_q <= REQ;
            owner_q <= OWN_IFU;
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q  <= OWN_IFU;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = gnt_ifu;
  assign lsu_req_ready  = gnt_lsu;
  assign mem_req_valid  = (state_q == REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  // Responses outside WAIT are stale or spurious and never reach a requester.
  assign ifu_resp_valid = (state_q == WAIT) && mem_resp_valid && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state_q == WAIT) && mem_resp_valid && (owner_q == OWN_LSU);
  assign resp_rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural memory, request drivers, response monitor.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [DW-1:0] ifu_addr;
  logic          lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_wen;
  logic [DW-1:0] lsu_addr, lsu_wdata, resp_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  mem_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        lsu;
    logic        wen;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Memory model: ready/stall decided and responses driven on the falling edge.
  int          stall_left = 0;
  int          resp_delay = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_rdata = '0;
  bit          inject = 1'b0;
  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_rdata      = '0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = pend_rdata;
        end
      end
      if (inject) begin
        inject         = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBAD0_BAD0;
      end
      if (mem_req_valid && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) begin
          pend_cnt   = resp_delay;
          pend_rdata = mem_fn(mem_addr);
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (ifu_req_valid && lsu_req_valid)
        chk("rdy_excl", {31'b0, ifu_req_ready & lsu_req_ready}, 32'd0);
      if (ifu_resp_valid || lsu_resp_valid) begin
        chk("resp_excl", {31'b0, ifu_resp_valid & lsu_resp_valid}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexp_resp", {30'b0, lsu_resp_valid, ifu_resp_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_port", {31'b0, lsu_resp_valid}, {31'b0, e.lsu});
          if (!e.wen) chk("resp_rdata", resp_rdata, e.rdata);
        end
      end
    end
  end

  task automatic drive_req(input logic lsu, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [3:0] wm,
                           output int gcyc, output int waited);
    int n = 0;
    @(negedge clk);
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = a;
    end
    gcyc = -1;
    forever begin
      #3;
      if (lsu ? lsu_req_ready : ifu_req_ready) begin
        gcyc = cyc;
        break;
      end
      n++;
      if (n > 200) break;
      @(negedge clk);
    end
    waited = n;
    if (gcyc < 0) chk("grant_timeout", n, 32'd0);
    @(posedge clk);
    #1;
    if (lsu) lsu_req_valid = 1'b0;
    else ifu_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #5;
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    int g_i, g_l, w_i, w_l, gap;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;

    // Reset state, with requests pending against it.
    @(negedge clk);
    ifu_req_valid = 1; lsu_req_valid = 1;
    #3;
    chk("rst_ifu_rdy", {31'b0, ifu_req_ready}, 32'd0);
    chk("rst_lsu_rdy", {31'b0, lsu_req_ready}, 32'd0);
    chk("rst_mreq", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    ifu_req_valid = 0; lsu_req_valid = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Minimum-latency IFU fetch.
    sb.push_back('{1'b0, 1'b0, 32'h0000_0413});
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #3;
    chk("t1_c0_ifu_rdy", {31'b0, ifu_req_ready}, 32'd1);
    chk("t1_c0_lsu_rdy", {31'b0, lsu_req_ready}, 32'd0);
    chk("t1_c0_mreq", {31'b0, mem_req_valid}, 32'd0);
    @(posedge clk);
    #1 ifu_req_valid = 0;
    @(negedge clk); #3;
    chk("t1_c1_mreq", {31'b0, mem_req_valid}, 32'd1);
    chk("t1_c1_maddr", mem_addr, 32'h8000_0000);
    chk("t1_c1_mwen", {31'b0, mem_wen}, 32'd0);
    chk("t1_c1_mwmask", {28'b0, mem_wmask}, 32'd0);
    @(negedge clk); #3;
    chk("t1_c2_resp", {31'b0, ifu_resp_valid}, 32'd1);
    chk("t1_c2_rdata", resp_rdata, 32'h0000_0413);
    chk("t1_c2_mreq", {31'b0, mem_req_valid}, 32'd0);
    drain();

    // Simultaneous requests.
`ifdef MEM_ARB_RR_EN
    sb.push_back('{1'b0, 1'b0, mem_fn(32'h8000_0100)});
    sb.push_back('{1'b1, 1'b0, mem_fn(32'h8000_2000)});
`else
    sb.push_back('{1'b1, 1'b0, mem_fn(32'h8000_2000)});
    sb.push_back('{1'b0, 1'b0, mem_fn(32'h8000_0100)});
`endif
    fork
      drive_req(1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'h0, g_l, w_l);
      drive_req(1'b0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, g_i, w_i);
    join
`ifdef MEM_ARB_RR_EN
    gap = g_l - g_i;
`else
    gap = g_i - g_l;
`endif
    chk("t2_gap", gap, 32'd3);
    drain();

    // Store with memory stalling for 4 cycles.
    sb.push_back('{1'b1, 1'b1, 32'h0});
    stall_left = 4;
    drive_req(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, g_l, w_l);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      chk("t3_mreq", {31'b0, mem_req_valid}, 32'd1);
      chk("t3_maddr", mem_addr, 32'h8000_1000);
      chk("t3_mwdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t3_mwmask", {28'b0, mem_wmask}, 32'hF);
      chk("t3_mwen", {31'b0, mem_wen}, 32'd1);
    end
    @(negedge clk); #3;
    chk("t3_mreq_done", {31'b0, mem_req_valid}, 32'd0);
    chk("t3_ack", {31'b0, lsu_resp_valid}, 32'd1);
    @(negedge clk); #3;
    chk("t3_ack_once", {31'b0, lsu_resp_valid}, 32'd0);
    drain();

    // Spurious memory response while idle.
    @(negedge clk);
    #1 inject = 1;
    @(negedge clk); #3;
    chk("t4_ifu_resp", {31'b0, ifu_resp_valid}, 32'd0);
    chk("t4_lsu_resp", {31'b0, lsu_resp_valid}, 32'd0);
    chk("t4_mreq", {31'b0, mem_req_valid}, 32'd0);
    sb.push_back('{1'b0, 1'b0, mem_fn(32'h8000_0200)});
    drive_req(1'b0, 32'h8000_0200, 1'b0, 32'h0, 4'h0, g_i, w_i);
    chk("t4_nowait", w_i, 32'd0);
    drain();

    // Reset during WAIT, stale response afterwards.
    resp_delay = 6;
    drive_req(1'b0, 32'h8000_3000, 1'b0, 32'h0, 4'h0, g_i, w_i);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0; ifu_req_valid = 1; lsu_req_valid = 1;
    #3;
    chk("t5_mreq", {31'b0, mem_req_valid}, 32'd0);
    chk("t5_ifu_rdy", {31'b0, ifu_req_ready}, 32'd0);
    chk("t5_lsu_rdy", {31'b0, lsu_req_ready}, 32'd0);
    chk("t5_ifu_resp", {31'b0, ifu_resp_valid}, 32'd0);
    chk("t5_lsu_resp", {31'b0, lsu_resp_valid}, 32'd0);
    chk("t5_maddr", mem_addr, 32'd0);
    ifu_req_valid = 0; lsu_req_valid = 0;
    @(negedge clk);
    rst_n = 1;
    resp_delay = 1;
    repeat (8) @(negedge clk);
    sb.push_back('{1'b0, 1'b0, mem_fn(32'h8000_0400)});
    drive_req(1'b0, 32'h8000_0400, 1'b0, 32'h0, 4'h0, g_i, w_i);
    chk("t5_nowait", w_i, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous, active-low.
REQ-002 Parameter DATA_W, default 32: width of address, read data and write data.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ifu_req_valid  input  1  instruction-fetch request.
REQ-006 ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-007 ifu_addr  input  DATA_W  fetch address.
REQ-008 ifu_resp_valid  output  1  fetch data valid, one-cycle pulse.
REQ-009 lsu_req_valid  input  1  load/store request.
REQ-010 lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-011 lsu_addr  input  DATA_W  load/store address.
REQ-012 lsu_wen  input  1  1 = store, 0 = load.
REQ-013 lsu_wdata  input  DATA_W  store data.
REQ-014 lsu_wmask  input  DATA_W/8  store byte mask.
REQ-015 lsu_resp_valid  output  1  load data or store completion, one-cycle pulse.
REQ-016 resp_rdata  output  DATA_W  read data, shared by both requesters.
REQ-017 mem_req_valid  output  1  request to the single memory port.
REQ-018 mem_req_ready  input  1  memory accepts the request.
REQ-019 mem_addr, mem_wen, mem_wdata, mem_wmask  output  DATA_W, 1, DATA_W, DATA_W/8  latched request fields.
REQ-020 mem_resp_valid  input  1  memory response (read data or write acknowledge).
REQ-021 mem_rdata  input  DATA_W  memory read data.

Function
REQ-022 FSM states SHALL be IDLE, REQ and WAIT, plus a 1-bit owner register (IFU or LSU).
REQ-023 IDLE: if any req_valid is high, the arbiter SHALL assert the winner's req_ready combinationally in that cycle, latch its addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and owner, and enter REQ.
REQ-024 req_ready SHALL be 0 outside IDLE and SHALL never be asserted to both requesters at once.
REQ-025 REQ: mem_req_valid=1 with latched fields; mem_req_ready=1 -> WAIT; otherwise hold, with fields stable.
REQ-026 WAIT: mem_resp_valid=1 -> assert owner's resp_valid for exactly that cycle, resp_rdata=mem_rdata combinationally, and return to IDLE.
REQ-027 Minimum latency SHALL be accept (cycle 0) -> mem_req_valid (cycle 1) -> response (cycle 2 at earliest); back-to-back grants SHALL be separated by at least 3 cycles.
REQ-028 Stores SHALL complete only on mem_resp_valid; lsu_resp_valid SHALL pulse for stores, with resp_rdata don't-care.
REQ-029 mem_resp_valid in IDLE or REQ SHALL be ignored: no resp_valid, no state change.
REQ-030 The losing requester SHALL be held off by req_ready=0 and SHALL NOT be buffered; it re-arbitrates in the next IDLE.
REQ-031 Default arbitration: on simultaneous requests, LSU SHALL win.
REQ-032 mem_req_valid SHALL be 0 in IDLE and WAIT.

Reset
REQ-033 rst_n low SHALL force IDLE, owner=IFU, latched fields=0 and all valid/ready outputs=0 immediately, even mid-transaction; a later stale mem_resp_valid SHALL be ignored per REQ-029.
REQ-034 Round-robin last-grant register, when present, SHALL reset to LSU.

Configuration
REQ-035 Macro MEM_ARB_RR_EN defined: simultaneous requests SHALL be granted to the requester not granted last, so IFU wins the first conflict after reset; single requests update last-grant.
REQ-036 MEM_ARB_RR_EN undefined: fixed LSU priority per REQ-031, with no last-grant register.

Verification
REQ-037 IFU alone, addr 0x80000000, mem_req_ready=1, response after 1 cycle with rdata 0x00000413 -> ifu_req_ready at cycle 0, mem_req_valid at cycle 1, ifu_resp_valid with resp_rdata 0x00000413 at cycle 2.
REQ-038 IFU and LSU request in the same cycle, no macro -> LSU granted first, IFU granted in the IDLE after LSU's response; with MEM_ARB_RR_EN -> IFU first, then LSU.
REQ-039 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready low 4 cycles -> mem_req_valid and fields held constant for 5 cycles, then lsu_resp_valid pulses once on the acknowledge.
REQ-040 mem_resp_valid pulsed while IDLE -> no resp_valid, state stays IDLE.
REQ-041 rst_n low during WAIT, then a memory response arrives after release -> outputs 0 immediately, response ignored, next IFU request served normally.
